// File: rtl/player_motion_ctrl.sv
// Two-player sprite motion controller: decodes PS/2 make/break codes into held-key
// bits and steps both sprites once per vertical-sync falling edge, clamped to the screen.
module player_motion_ctrl #(
    parameter int STEP   = 2,
    parameter int SPRITE = 32,
    parameter int X_MAX  = 640,
    parameter int Y_MAX  = 480,
    parameter int P0_X0  = 64,
    parameter int P0_Y0  = 64,
    parameter int P1_X0  = 544,
    parameter int P1_Y0  = 384
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [7:0]  ps2_key_data,
    input  logic        ps2_key_pressed,
    input  logic        vs_n,
    output logic [31:0] player0_x,
    output logic [31:0] player0_y,
    output logic [31:0] player1_x,
    output logic [31:0] player1_y,
    output logic        frame_tick
);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] X_LIM  = 11'(X_MAX - SPRITE);
    localparam logic [10:0] Y_LIM  = 11'(Y_MAX - SPRITE);

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_held;
    logic [7:0]  w_key_hit;
    logic [7:0]  w_set;
    logic [7:0]  w_clr;
    logic        r_vs_prev;
    logic        r_live;
    logic        w_tick;
    logic        r_frame_tick;
    logic [9:0]  r_p0_x;
    logic [8:0]  r_p0_y;
    logic [9:0]  r_p1_x;
    logic [8:0]  r_p1_y;

    // Held-bit layout per player: [0]=up [1]=down [2]=left [3]=right; player1 in [7:4].
    always_comb begin
        w_key_hit = 8'd0;
        case (ps2_key_data)
            8'h1D: w_key_hit[0] = 1'b1;
            8'h1B: w_key_hit[1] = 1'b1;
            8'h1C: w_key_hit[2] = 1'b1;
            8'h23: w_key_hit[3] = 1'b1;
            8'h43: w_key_hit[4] = 1'b1;
            8'h42: w_key_hit[5] = 1'b1;
            8'h3B: w_key_hit[6] = 1'b1;
            8'h4B: w_key_hit[7] = 1'b1;
            default: w_key_hit = 8'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_set        = 8'd0;
        w_clr        = 8'd0;
        if (ps2_key_pressed) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_key_data == BRK_CODE)      w_next_state = S_BRK;
                    else if (ps2_key_data == EXT_CODE) w_next_state = S_EXT;
                    else                               w_set = w_key_hit;
                end
                S_BRK: begin
                    w_clr        = w_key_hit;
                    w_next_state = S_IDLE;
                end
                S_EXT:   w_next_state = (ps2_key_data == BRK_CODE) ? S_EXT_BRK : S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_held  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_held  <= (r_held | w_set) & ~w_clr;
        end
    end

    // r_live masks the first cycle after release so a vs_n already low then is not an edge.
    assign w_tick = r_vs_prev & ~vs_n & r_live;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_vs_prev    <= 1'b1;
            r_live       <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_prev    <= vs_n;
            r_live       <= 1'b1;
            r_frame_tick <= w_tick;
        end
    end

    function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic dec,
                                              input logic inc, input logic [10:0] lim);
        logic [10:0] nxt;
        nxt = pos;
        if (dec && !inc)
            nxt = (pos < STEP_W) ? 11'd0 : pos - STEP_W;
        else if (inc && !dec)
            nxt = (pos + STEP_W > lim) ? lim : pos + STEP_W;
        return nxt;
    endfunction

    // Update happens on the edge closing the frame_tick cycle, so a key strobe in
    // that same cycle lands in r_held only after the move has used the old bits.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_p0_x <= 10'(P0_X0);
            r_p0_y <= 9'(P0_Y0);
            r_p1_x <= 10'(P1_X0);
            r_p1_y <= 9'(P1_Y0);
        end else if (r_frame_tick) begin
            r_p0_x <= 10'(step_axis({1'b0, r_p0_x}, r_held[2], r_held[3], X_LIM));
            r_p0_y <= 9'(step_axis({2'b0, r_p0_y}, r_held[0], r_held[1], Y_LIM));
            r_p1_x <= 10'(step_axis({1'b0, r_p1_x}, r_held[6], r_held[7], X_LIM));
            r_p1_y <= 9'(step_axis({2'b0, r_p1_y}, r_held[4], r_held[5], Y_LIM));
        end
    end

    assign player0_x  = {22'd0, r_p0_x};
    assign player0_y  = {23'd0, r_p0_y};
    assign player1_x  = {22'd0, r_p1_x};
    assign player1_y  = {23'd0, r_p1_y};
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed plus randomized bench for player_motion_ctrl against a key/position model.
module tb_player_motion_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [7:0]  ps2_key_data;
    logic        ps2_key_pressed;
    logic        vs_n;
    logic [31:0] player0_x, player0_y, player1_x, player1_y;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: held keys, prefix state, positions as plain ints.
    bit m_held[8];
    int m_mode;           // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    int m_x[2], m_y[2];

    player_motion_ctrl dut (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .ps2_key_data   (ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed),
        .vs_n           (vs_n),
        .player0_x      (player0_x),
        .player0_y      (player0_y),
        .player1_x      (player1_x),
        .player1_y      (player1_y),
        .frame_tick     (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int key_index(input logic [7:0] b);
        case (b)
            8'h1D: return 0;  8'h1B: return 1;  8'h1C: return 2;  8'h23: return 3;
            8'h43: return 4;  8'h42: return 5;  8'h3B: return 6;  8'h4B: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_mode = 0;
        m_x[0] = 64;  m_y[0] = 64;
        m_x[1] = 544; m_y[1] = 384;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = key_index(b);
        case (m_mode)
            0: if (b == 8'hF0) m_mode = 1;
               else if (b == 8'hE0) m_mode = 2;
               else if (k >= 0) m_held[k] = 1'b1;
            1: begin if (k >= 0) m_held[k] = 1'b0; m_mode = 0; end
            2: m_mode = (b == 8'hF0) ? 3 : 0;
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_tick();
        for (int p = 0; p < 2; p++) begin
            m_y[p] = clamp(m_y[p] + 2 * (int'(m_held[4*p+1]) - int'(m_held[4*p])), 448);
            m_x[p] = clamp(m_x[p] + 2 * (int'(m_held[4*p+3]) - int'(m_held[4*p+2])), 608);
        end
    endtask

    task automatic check_pos(input string tag);
        chk({tag, ".p0x"}, player0_x, 32'(m_x[0]));
        chk({tag, ".p0y"}, player0_y, 32'(m_y[0]));
        chk({tag, ".p1x"}, player1_x, 32'(m_x[1]));
        chk({tag, ".p1y"}, player1_y, 32'(m_y[1]));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge vga_clk);
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        @(negedge vga_clk);
        ps2_key_pressed = 1'b0;
        model_byte(b);
    endtask

    // One vs_n low period held for several cycles; expects exactly one frame_tick pulse.
    task automatic do_tick(input string tag);
        int pulses;
        pulses = 0;
        @(negedge vga_clk);
        vs_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge vga_clk);
            if (frame_tick) pulses++;
        end
        vs_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge vga_clk);
            if (frame_tick) pulses++;
        end
        model_tick();
        chk({tag, ".pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int pulses;
        int sel;
        ps2_key_data    = 8'h00;
        ps2_key_pressed = 1'b0;
        vs_n            = 1'b1;
        reset           = 1'b1;
        model_reset();
        repeat (2) @(negedge vga_clk);
        check_pos("reset");
        chk("reset.tick", 32'(frame_tick), 32'd0);

        // vs_n already low when reset releases: no tick.
        vs_n = 1'b0;
        @(negedge vga_clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge vga_clk);
            if (frame_tick) pulses++;
        end
        vs_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("release_low.pulses", 32'(pulses), 32'd0);
        check_pos("release_low");

        // Hold D: three ticks step player0 right.
        send_byte(8'h23);
        for (int t = 0; t < 3; t++) begin
            do_tick("hold_d");
            check_pos("hold_d");
        end
        chk("hold_d.x70", player0_x, 32'd70);

        // Release D: no further motion.
        send_byte(8'hF0);
        send_byte(8'h23);
        do_tick("rel_d");
        do_tick("rel_d");
        check_pos("rel_d");

        // Hold A from 70 down to the left wall.
        send_byte(8'h1C);
        for (int t = 0; t < 40; t++) begin
            do_tick("hold_a");
            if (t == 34) chk("hold_a.zero", player0_x, 32'd0);
        end
        check_pos("hold_a");
        send_byte(8'hF0); send_byte(8'h1C);

        // Hold L: player1 saturates on the right wall.
        send_byte(8'h4B);
        for (int t = 0; t < 40; t++) do_tick("hold_l");
        chk("hold_l.sat", player1_x, 32'd608);
        check_pos("hold_l");
        send_byte(8'hF0); send_byte(8'h4B);

        // Extended W make/break: ignored.
        send_byte(8'hE0); send_byte(8'h1D);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1D);
        do_tick("ext");
        check_pos("ext");
        // Decoder back to idle: a plain S make now registers.
        send_byte(8'h1B);
        do_tick("ext_idle");
        check_pos("ext_idle");

        // W and S together cancel.
        send_byte(8'h1D);
        do_tick("ws");
        chk("ws.y", player0_y, 32'(m_y[0]));
        check_pos("ws");
        send_byte(8'hF0); send_byte(8'h1D);
        send_byte(8'hF0); send_byte(8'h1B);

        // Strobe I during the frame_tick cycle: takes effect next tick.
        @(negedge vga_clk);
        vs_n = 1'b0;
        pulses = 0;
        @(negedge vga_clk);
        if (frame_tick) pulses++;
        ps2_key_data    = 8'h43;
        ps2_key_pressed = 1'b1;
        @(negedge vga_clk);
        ps2_key_pressed = 1'b0;
        if (frame_tick) pulses++;
        repeat (3) @(negedge vga_clk);
        vs_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        model_tick();
        model_byte(8'h43);
        chk("same_cyc.pulses", 32'(pulses), 32'd1);
        chk("same_cyc.p1y", player1_y, 32'd384);
        do_tick("same_next");
        chk("same_next.p1y", player1_y, 32'd382);
        send_byte(8'hF0); send_byte(8'h43);

        // Randomized bytes and ticks.
        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(0, 14));
            if (sel < 8) begin
                case (sel)
                    0: b = 8'h1D; 1: b = 8'h1B; 2: b = 8'h1C; 3: b = 8'h23;
                    4: b = 8'h43; 5: b = 8'h42; 6: b = 8'h3B; default: b = 8'h4B;
                endcase
                send_byte(b);
            end else if (sel == 8) send_byte(8'hF0);
            else if (sel == 9)     send_byte(8'hE0);
            else if (sel == 10)    send_byte(8'($urandom_range(0, 255)));
            else begin
                do_tick("rand");
                check_pos("rand");
            end
        end

        // Reset mid-hold: asynchronous return to start and held bits cleared.
        send_byte(8'hF0); send_byte(8'h00);
        model_reset();
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        send_byte(8'h23);
        for (int t = 0; t < 5; t++) do_tick("pre_rst");
        chk("pre_rst.x", player0_x, 32'd74);
        @(negedge vga_clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_pos("async_rst");
        chk("async_rst.tick", 32'(frame_tick), 32'd0);
        @(negedge vga_clk);
        reset = 1'b0;
        do_tick("post_rst");
        do_tick("post_rst");
        check_pos("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
